// File: rtl/lvds_rx.sv
// Forwarded-clock serial receiver: oversamples rxclk/rx in the clk domain, shifts
// bits in MSB-first on each rxclk rise and realigns to a byte MSB after link idle.
module lvds_rx #(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxclk,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       err,
    output logic       active
);

    localparam int CW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] rxclk_sync;
    logic [SYNC_STAGES-1:0] rx_sync;
    logic                   rxclk_d;
    logic                   rise_det;
    logic                   rise;
    logic                   rise_bit;
    state_t                 state;
    logic [7:0]             shift;
    logic [2:0]             bitcnt;
    logic [CW-1:0]          idle_cnt;
    logic                   done;

    assign rise_det = rxclk_sync[SYNC_STAGES-1] & ~rxclk_d;

    // Synchronisers, edge detect, and an aligned edge/data sample stage
    always_ff @(posedge clk) begin
        if (rst) begin
            rxclk_sync <= '0;
            rx_sync    <= '0;
            rxclk_d    <= 1'b0;
            rise       <= 1'b0;
            rise_bit   <= 1'b0;
        end else begin
            rxclk_sync <= {rxclk_sync[SYNC_STAGES-2:0], rxclk};
            rx_sync    <= {rx_sync[SYNC_STAGES-2:0], rx};
            rxclk_d    <= rxclk_sync[SYNC_STAGES-1];
            rise       <= rise_det;
            rise_bit   <= rx_sync[SYNC_STAGES-1];
        end
    end

    // Receive FSM: bit assembly, idle timeout and registered output strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= 8'h00;
            bitcnt   <= 3'd0;
            idle_cnt <= '0;
            done     <= 1'b0;
            data     <= 8'h00;
            valid    <= 1'b0;
            err      <= 1'b0;
            active   <= 1'b0;
        end else begin
            valid <= done;
            done  <= 1'b0;
            err   <= 1'b0;
            if (done) begin
                data <= shift;
            end else begin
                data <= data;
            end
            case (state)
                IDLE: begin
                    bitcnt   <= 3'd0;
                    idle_cnt <= '0;
                    if (rise) begin
                        shift  <= {shift[6:0], rise_bit};
                        bitcnt <= 3'd1;
                        state  <= RECV;
                        active <= 1'b1;
                    end else begin
                        active <= 1'b0;
                    end
                end
                RECV: begin
                    // An edge wins over a timeout landing in the same cycle
                    if (rise) begin
                        shift    <= {shift[6:0], rise_bit};
                        bitcnt   <= bitcnt + 3'd1;
                        idle_cnt <= '0;
                        done     <= (bitcnt == 3'd7);
                        active   <= 1'b1;
                    end else if (idle_cnt == CW'(IDLE_TIMEOUT - 1)) begin
                        state    <= IDLE;
                        err      <= (bitcnt != 3'd0);
                        bitcnt   <= 3'd0;
                        idle_cnt <= '0;
                        active   <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                        active   <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lvds_rx.md
Name: lvds_rx

Overview:
- Serial receiver for the forwarded-clock link driven by LVDS_TX: a clock line (rxclk) plus a one-bit data line (rx).
- Oversamples both lines in the system clock domain, detects rxclk rising edges and shifts rx in MSB-first.
- Emits one 8-bit byte with a single-cycle valid strobe.
- Aligns bytes by link idle: the first bit after an idle gap is always a byte MSB. Sits at the FPGA input of the link, feeding the downstream data path.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on rxclk and rx (min 2).
- IDLE_TIMEOUT, 64, clk cycles without an rxclk rising edge before the link is declared idle (min 4).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- rxclk  input  1  forwarded serial clock, asynchronous to clk.
- rx  input  1  serial data; launched on rxclk falling edge, sampled on the rising edge.
- data  output  8  last received byte.
- valid  output  1  one-cycle strobe; data is new this cycle.
- err  output  1  one-cycle strobe; partial byte discarded on idle timeout.
- active  output  1  high while in the RECV state.

Behaviour:
- Clock and reset
  - One clock (clk). Reset is synchronous, active-high (rst).
  - Reset values: data=0x00, valid=0, err=0, active=0. Synchronisers, shift register, bit counter and idle counter are all cleared; state=IDLE.
- Synchronisation
  - rxclk and rx each pass through SYNC_STAGES flops. The synchronised rxclk is delayed one more flop.
  - edge = sync_rxclk & ~rxclk_d.
  - rx is sampled from its synchroniser output in the edge cycle. Both paths have equal depth.
- Input constraint: rxclk high and low times are each >= 2 clk periods. Faster input is out of spec and behaviour is undefined.
- State IDLE
  - active=0, bitcnt=0.
  - On edge: shift in the bit, bitcnt=1, go to RECV, clear the idle counter.
- State RECV
  - active=1.
  - On edge: shift reg = {shift[6:0], rx}, bitcnt++, clear the idle counter.
  - When the 8th bit shifts in (bitcnt 7->0): in the following cycle data = the assembled byte and valid=1 for exactly one cycle. The state stays RECV with bitcnt=0, so back-to-back bytes are seamless.
  - With no edge: the idle counter increments, saturating.
  - When it reaches IDLE_TIMEOUT: go to IDLE.
    - If bitcnt != 0, pulse err for one cycle and discard the partial byte; data is unchanged.
    - If bitcnt == 0, there is no err.
- Latency: valid rises SYNC_STAGES+2 clk cycles after the first clk edge that samples the 8th raw rxclk rise high.
- Simultaneous events: an edge in the same cycle the idle counter would expire takes priority. The bit is accepted, the counter cleared and there is no timeout.
- valid and err are never high in the same cycle.
- data holds its value between valid strobes.
- There is no backpressure; the consumer must accept every valid.
- Reset mid-byte: the partial byte is lost and there is no err. The first edge after reset is treated as an MSB.

Test Plan:
1. Reset, then send 0xA5 with a rxclk period of 32 clk (half 16) -> exactly one valid, data=0xA5, err never high, active=1 from the first edge until IDLE_TIMEOUT cycles after the last edge.
2. Continuous stream 0x00,0x01,...,0x63 with no gaps (100 bytes, matching the LVDS_TX bench) -> 100 valid pulses, data increments by 1 each time, spacing 8 rxclk periods, err=0.
3. Send 5 bits (10110), then hold rxclk low for 100 clk -> err pulses once, no valid, active falls. Then send 0x3C -> valid with data=0x3C (alignment recovered).
4. Send 0xFF, idle 200 clk, send 0x81 -> two valids (0xFF, 0x81), no err, active drops between the bytes.
5. Assert rst for 1 cycle after 3 bits of 0xC3 -> outputs return to reset values, no err. A following full 0x5A yields data=0x5A.
6. Minimum timing: rxclk high 2 / low 2 clk, byte 0x96 -> valid with data=0x96. Check valid latency equals SYNC_STAGES+2 from the 8th raw rise.
